// File: rtl/row_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : row_sched_pkg
// Description : Shared state encoding and width helpers for the row sample
//               scheduler and its request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package row_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

    // Minimum width of one bit, so a single-row matrix still gets an index bus.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

    function automatic int row_width(input int max_height);
        return clog2_min1(max_height);
    endfunction

    function automatic int idx_width(input int target_rows);
        return clog2_min1(target_rows);
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : row_req_fifo
// Description : Synchronous first-word-fall-through FIFO with flush, full and
//               empty flags; a pop frees a slot for a push in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module row_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/row_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : row_sample_scheduler
// Description : Bresenham vertical decimation of incoming video rows onto the
//               LED matrix rows; queues one transfer request per chosen row.
//               Optional macro ROW_SCHED_STATS_EN adds O_dropped_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module row_sample_scheduler
    import row_sched_pkg::*;
#(
    parameter int MAX_HEIGHT  = 1080,
    parameter int TARGET_ROWS = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                 I_rgb_clk,
    input  logic                                 I_rst,
    input  logic                                 I_new_frame,
    input  logic                                 I_new_row,
    input  logic                                 I_image_valid,
    input  logic [row_width(MAX_HEIGHT)-1:0]     I_image_height,
    output logic                                 O_req_valid,
    input  logic                                 I_req_ready,
    output logic [idx_width(TARGET_ROWS)-1:0]    O_req_row,
    output logic [row_width(MAX_HEIGHT)-1:0]     O_req_src_row,
    output logic                                 O_frame_done,
    output logic                                 O_busy,
`ifdef ROW_SCHED_STATS_EN
    output logic [15:0]                          O_dropped_cnt,
`endif
    output logic                                 O_overrun
);

    localparam int c_ROW_W   = row_width(MAX_HEIGHT);
    localparam int c_IDX_W   = idx_width(TARGET_ROWS);
    localparam int c_ACC_W   = c_ROW_W + 1;
    localparam int c_ENTRY_W = c_IDX_W + c_ROW_W;

    localparam logic [c_ACC_W-1:0] c_TGT      = c_ACC_W'(TARGET_ROWS);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(TARGET_ROWS - 1);
    localparam logic [c_ROW_W-1:0] c_SRC_MAX  = c_ROW_W'(MAX_HEIGHT - 1);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_ACC_W-1:0]   w_acc_nxt;
    logic [c_ACC_W-1:0]   w_acc_sum;
    logic [c_ROW_W-1:0]   r_src_row;
    logic [c_ROW_W-1:0]   w_src_nxt;
    logic [c_IDX_W-1:0]   r_target_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [c_ROW_W-1:0]   r_height;
    logic [c_ROW_W-1:0]   w_height_nxt;
    logic                 w_push;
    logic                 w_flush;
    logic                 w_frame_done_nxt;
    logic                 w_premature;
    logic                 r_frame_done;
    logic                 r_overrun;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_ENTRY_W-1:0] w_fifo_out;

    always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority: geometry loss, then frame start, then row boundary.
    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_src_nxt        = r_src_row;
        w_idx_nxt        = r_target_idx;
        w_height_nxt     = r_height;
        w_push           = 1'b0;
        w_flush          = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_premature      = 1'b0;
        w_acc_sum        = r_acc + c_TGT;

        if (!I_image_valid) begin
            w_state_nxt = IDLE;
            w_flush     = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if ({1'b0, I_image_height} >= c_TGT) begin
                        w_state_nxt = ARMED;
                    end
                end
                ARMED, DONE, ACTIVE: begin
                    if (I_new_frame) begin
                        w_state_nxt  = ACTIVE;
                        w_acc_nxt    = '0;
                        w_src_nxt    = '0;
                        w_idx_nxt    = '0;
                        w_height_nxt = I_image_height;
                        // Leaving ACTIVE always means the last target was issued,
                        // so a frame start seen here cut the previous frame short.
                        w_premature  = (r_state == ACTIVE);
                    end else if (I_new_row && (r_state == ACTIVE)) begin
                        if (r_src_row != c_SRC_MAX) begin
                            w_src_nxt = r_src_row + 1'b1;
                        end
                        if (w_acc_sum >= {1'b0, r_height}) begin
                            w_acc_nxt = w_acc_sum - {1'b0, r_height};
                            w_push    = 1'b1;
                            if (r_target_idx == c_IDX_LAST) begin
                                w_frame_done_nxt = 1'b1;
                                w_state_nxt      = DONE;
                            end else begin
                                w_idx_nxt = r_target_idx + 1'b1;
                            end
                        end else begin
                            w_acc_nxt = w_acc_sum;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
            r_acc        <= '0;
            r_src_row    <= '0;
            r_target_idx <= '0;
            r_height     <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_acc        <= w_acc_nxt;
            r_src_row    <= w_src_nxt;
            r_target_idx <= w_idx_nxt;
            r_height     <= w_height_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overrun    <= r_overrun | w_drop | w_premature;
        end
    end

    assign w_pop  = O_req_valid & I_req_ready;
    assign w_drop = w_push & w_fifo_full & ~w_pop;

    row_req_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (I_rgb_clk),
        .rst     (I_rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  ({r_target_idx, r_src_row}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign O_req_valid   = ~w_fifo_empty;
    assign O_req_row     = w_fifo_out[c_ENTRY_W-1 -: c_IDX_W];
    assign O_req_src_row = w_fifo_out[c_ROW_W-1:0];
    assign O_frame_done  = r_frame_done;
    assign O_busy        = (r_state == ACTIVE);
    assign O_overrun     = r_overrun;

`ifdef ROW_SCHED_STATS_EN
    logic [15:0] r_dropped_cnt;

    always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
            r_dropped_cnt <= '0;
        end else if ((w_drop || w_premature) && (r_dropped_cnt != 16'hFFFF)) begin
            r_dropped_cnt <= r_dropped_cnt + 16'd1;
        end
    end

    assign O_dropped_cnt = r_dropped_cnt;
`endif

endmodule
`default_nettype wire
